apb_dmem_completer: RTL

APB completer (slave) fronting the core's data memory, the responder end of the data-memory APB link driven by the load/store unit's APB controller. It decodes a configurable address window, performs byte-strobed word writes and word reads into a synchronous-read SRAM, inserts a programmable number of wait states, and signals out-of-window accesses with PSLVERR. It sits at the top level between the core's data APB interface and on-chip RAM.

---
 rtl/apb_dmem_completer_pkg.sv | 28 ++
 rtl/apb_if.sv | 24 ++
 rtl/dmem_sram.sv | 28 ++
 rtl/apb_dmem_completer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/apb_dmem_completer_pkg.sv
// Shared types and address-window helper for the data-memory APB completer.
package apb_dmem_completer_pkg;

  localparam int APB_STRB_W = 4;
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_cmp_state_e;

  // True when addr falls outside [base, base + 4*depth_words).
  // The comparison is done in 33 bits so that a window ending at 4 GiB does not wrap.
  function automatic logic addr_out_of_window(input logic [APB_ADDR_W-1:0] addr,
                                              input logic [APB_ADDR_W-1:0] base,
                                              input int unsigned           depth_words);
    logic [APB_ADDR_W:0] a;
    logic [APB_ADDR_W:0] lo;
    logic [APB_ADDR_W:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + ((APB_ADDR_W+1)'(depth_words) << 2);
    return (a < lo) || (a >= hi);
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB signal bundle between the load/store unit's APB requester and the data-memory completer.
interface apb_if;
  import apb_dmem_completer_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_STRB_W-1:0] pstrb;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/dmem_sram.sv
// Single-port synchronous-read RAM with per-byte write enables (inferable).
module dmem_sram
  import apb_dmem_completer_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [APB_STRB_W-1:0] we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [APB_DATA_W-1:0] wdata,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane writes and read-first registered read on every enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < APB_STRB_W; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_dmem_completer.sv
// APB completer for the core data memory: window decode, wait states, byte-strobed writes.
module apb_dmem_completer
  import apb_dmem_completer_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000,
  parameter int              WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  apb_if.slave       apb,
  output logic [7:0] err_cnt_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  apb_cmp_state_e        state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [APB_STRB_W-1:0] strb_q, strb_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  setup;
  logic                  err_now;
  logic                  sram_en;
  logic [APB_STRB_W-1:0] sram_we;
  logic [AW-1:0]         sram_addr;
  logic [APB_DATA_W-1:0] sram_rdata;
  logic                  commit;

  assign setup   = apb.psel & ~apb.penable;
  assign err_now = addr_out_of_window(apb.paddr, BASE_ADDR, DEPTH_WORDS);

  // Next-state, SETUP latching, wait countdown and saturating error count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    err_d     = err_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          write_d = apb.pwrite;
          strb_d  = apb.pstrb;
          wdata_d = apb.pwdata;
          idx_d   = apb.paddr[2 +: AW];
          err_d   = err_now;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!apb.psel) begin
          // Requester abandoned the transfer: drop it silently.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over everything, including a write committing this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      err_q     <= err_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // SRAM control: read issued at SETUP from live address, write committed in RESP from latched values.
  always_comb begin
    commit    = (state_q == RESP) && write_q && !err_q && !rst;
    sram_en   = commit ||
                ((state_q == IDLE) && setup && !apb.pwrite && !err_now && !rst);
    sram_we   = commit ? strb_q : '0;
    sram_addr = (state_q == IDLE) ? apb.paddr[2 +: AW] : idx_q;
  end

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .wdata(wdata_q),
    .rdata(sram_rdata)
  );

  // APB outputs decode registered state only; data and error are zero outside RESP.
  always_comb begin
    apb.pready  = (state_q == RESP);
    apb.pslverr = (state_q == RESP) && err_q;
    apb.prdata  = ((state_q == RESP) && !write_q && !err_q) ? sram_rdata : '0;
  end

  assign err_cnt_o = err_cnt_q;

endmodule
